// File: rtl/tx_control_pkg.sv
// Shared definitions for the TX/RX frame controllers: byte width and sequencer
// state encoding.
package tx_control_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_RD = 2'd1,
        SEND_LO = 2'd2,
        SEND_HI = 2'd3
    } tx_state_t;

endpackage

// File: rtl/tx_control_if.sv
// Result-source and TX-FIFO signals of the transmit frame sequencer.
// The master side drives results and FIFO status; the slave side is the sequencer.
interface tx_control_if;
    import tx_control_pkg::*;

    logic [WIDTH-1:0]   rd_data;
    logic               rd_valid;
    logic [2*WIDTH-1:0] alu_out;
    logic               out_valid;
    logic               fifo_full;
    logic [WIDTH-1:0]   wr_data;
    logic               wr_inc;
    logic               busy;
    logic               overrun;

    modport master (
        output rd_data, rd_valid, alu_out, out_valid, fifo_full,
        input  wr_data, wr_inc, busy, overrun
    );

    modport slave (
        input  rd_data, rd_valid, alu_out, out_valid, fifo_full,
        output wr_data, wr_inc, busy, overrun
    );

endinterface

// File: rtl/tx_control.sv
// Transmit frame sequencer: holds a register read (1 byte) or ALU result (2 bytes)
// and writes it into the TX FIFO one byte per cycle, stalling on FIFO full.
module tx_control
    import tx_control_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    tx_control_if.slave bus
);

    tx_state_t          state_q, state_d;
    logic [2*WIDTH-1:0] hold_q, hold_d;
    logic               overrun_q, overrun_d;
    logic               accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            overrun_q <= overrun_d;
        end
    end

    // A new result is taken in IDLE or in the cycle the last byte of a frame
    // leaves, so frames can follow each other without an idle bubble.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        overrun_d    = 1'b0;
        bus.wr_inc   = 1'b0;
        bus.wr_data  = hold_q[WIDTH-1:0];
        accept       = 1'b0;

        case (state_q)
            IDLE: begin
                accept = 1'b1;
            end
            SEND_RD: begin
                if (!bus.fifo_full) begin
                    bus.wr_inc = 1'b1;
                    state_d    = IDLE;
                    accept     = 1'b1;
                end
            end
            SEND_LO: begin
                if (!bus.fifo_full) begin
                    bus.wr_inc = 1'b1;
                    state_d    = SEND_HI;
                end
            end
            SEND_HI: begin
                bus.wr_data = hold_q[2*WIDTH-1:WIDTH];
                if (!bus.fifo_full) begin
                    bus.wr_inc = 1'b1;
                    state_d    = IDLE;
                    accept     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Register reads take priority; any result that cannot be taken is lost.
        if (accept) begin
            if (bus.rd_valid) begin
                hold_d    = {{WIDTH{1'b0}}, bus.rd_data};
                state_d   = SEND_RD;
                overrun_d = bus.out_valid;
            end else if (bus.out_valid) begin
                hold_d  = bus.alu_out;
                state_d = SEND_LO;
            end
        end else begin
            overrun_d = bus.rd_valid | bus.out_valid;
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_tx_control.sv
// Self-checking bench for tx_control: expected FIFO bytes are queued as results
// are offered and popped by a monitor whenever the sequencer strobes a write.
module tb_tx_control;
    import tx_control_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    logic [WIDTH-1:0] exp_q[$];

    tx_control_if tx();

    tx_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tx.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every write strobe must match the oldest byte still owed to the FIFO.
    always @(negedge clk) begin
        if (rst_n && tx.wr_inc === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_write: got wr_data=%h, expected no write", tx.wr_data);
            end else begin
                logic [WIDTH-1:0] exp_byte;
                exp_byte = exp_q.pop_front();
                if (tx.wr_data !== exp_byte) begin
                    miscompares++;
                    $display("[TB] FAIL write_data: got %h, expected %h", tx.wr_data, exp_byte);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_bit(input string name, input logic got, input logic want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b, expected %b", name, got, want);
        end
    endtask

    task automatic clear_inputs();
        tx.rd_valid  = 1'b0;
        tx.out_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        tx.rd_data   = '0;
        tx.alu_out   = '0;
        tx.fifo_full = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        expect_bit("reset_wr_inc", tx.wr_inc, 1'b0);
        expect_bit("reset_busy", tx.busy, 1'b0);
        expect_bit("reset_overrun", tx.overrun, 1'b0);
        vectors++;
        if (tx.wr_data !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_wr_data: got %h, expected 00", tx.wr_data);
        end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_single_read();
        tx.rd_valid = 1'b1;
        tx.rd_data  = 8'hA5;
        exp_q.push_back(8'hA5);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        expect_bit("read_wr_inc", tx.wr_inc, 1'b1);
        expect_bit("read_busy", tx.busy, 1'b1);
        next_cycle();
        @(negedge clk);
        expect_bit("read_idle_busy", tx.busy, 1'b0);
        expect_bit("read_idle_wr_inc", tx.wr_inc, 1'b0);
    endtask

    task automatic test_alu_result();
        tx.out_valid = 1'b1;
        tx.alu_out   = 16'h1234;
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h12);
        next_cycle();
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            expect_bit("alu_wr_inc", tx.wr_inc, 1'b1);
            expect_bit("alu_busy", tx.busy, 1'b1);
            next_cycle();
        end
        @(negedge clk);
        expect_bit("alu_idle_busy", tx.busy, 1'b0);
    endtask

    task automatic test_backpressure();
        tx.fifo_full = 1'b1;
        tx.out_valid = 1'b1;
        tx.alu_out   = 16'hBEEF;
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBE);
        next_cycle();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            expect_bit("stall_wr_inc", tx.wr_inc, 1'b0);
            expect_bit("stall_busy", tx.busy, 1'b1);
            vectors++;
            if (tx.wr_data !== 8'hEF) begin
                miscompares++;
                $display("[TB] FAIL stall_wr_data: got %h, expected ef", tx.wr_data);
            end
            next_cycle();
        end
        tx.fifo_full = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            expect_bit("unstall_wr_inc", tx.wr_inc, 1'b1);
            next_cycle();
        end
        @(negedge clk);
        expect_bit("unstall_idle_wr_inc", tx.wr_inc, 1'b0);
        expect_bit("unstall_idle_busy", tx.busy, 1'b0);
    endtask

    task automatic test_collision();
        tx.rd_valid  = 1'b1;
        tx.rd_data   = 8'h5A;
        tx.out_valid = 1'b1;
        tx.alu_out   = 16'h7777;
        exp_q.push_back(8'h5A);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        expect_bit("collision_overrun", tx.overrun, 1'b1);
        expect_bit("collision_wr_inc", tx.wr_inc, 1'b1);
        next_cycle();
        @(negedge clk);
        expect_bit("collision_overrun_clear", tx.overrun, 1'b0);
        expect_bit("collision_busy", tx.busy, 1'b0);
    endtask

    task automatic test_overrun_in_lo();
        tx.out_valid = 1'b1;
        tx.alu_out   = 16'hCAFE;
        exp_q.push_back(8'hFE);
        exp_q.push_back(8'hCA);
        next_cycle();
        clear_inputs();
        tx.rd_valid = 1'b1;
        tx.rd_data  = 8'h99;
        @(negedge clk);
        expect_bit("lo_drop_wr_inc", tx.wr_inc, 1'b1);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        expect_bit("lo_drop_overrun", tx.overrun, 1'b1);
        expect_bit("lo_drop_hi_wr_inc", tx.wr_inc, 1'b1);
        next_cycle();
        @(negedge clk);
        expect_bit("lo_drop_overrun_clear", tx.overrun, 1'b0);
        expect_bit("lo_drop_busy", tx.busy, 1'b0);
    endtask

    task automatic test_stall_drop();
        tx.fifo_full = 1'b1;
        tx.rd_valid  = 1'b1;
        tx.rd_data   = 8'h3C;
        exp_q.push_back(8'h3C);
        next_cycle();
        tx.rd_data = 8'h44;
        @(negedge clk);
        expect_bit("stalled_rd_wr_inc", tx.wr_inc, 1'b0);
        next_cycle();
        clear_inputs();
        tx.fifo_full = 1'b0;
        @(negedge clk);
        expect_bit("stalled_rd_overrun", tx.overrun, 1'b1);
        expect_bit("stalled_rd_release", tx.wr_inc, 1'b1);
        next_cycle();
        @(negedge clk);
        expect_bit("stalled_rd_busy", tx.busy, 1'b0);
        expect_bit("stalled_rd_overrun_clear", tx.overrun, 1'b0);
    endtask

    task automatic test_back_to_back();
        tx.out_valid = 1'b1;
        tx.alu_out   = 16'h2233;
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h22);
        next_cycle();
        clear_inputs();
        next_cycle();
        tx.rd_valid = 1'b1;
        tx.rd_data  = 8'h11;
        exp_q.push_back(8'h11);
        @(negedge clk);
        expect_bit("b2b_hi_wr_inc", tx.wr_inc, 1'b1);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        expect_bit("b2b_rd_wr_inc", tx.wr_inc, 1'b1);
        expect_bit("b2b_busy", tx.busy, 1'b1);
        expect_bit("b2b_overrun", tx.overrun, 1'b0);
        next_cycle();
        @(negedge clk);
        expect_bit("b2b_idle_busy", tx.busy, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        tx.out_valid = 1'b1;
        tx.alu_out   = 16'h5566;
        exp_q.push_back(8'h66);
        next_cycle();
        clear_inputs();
        next_cycle();
        rst_n = 1'b0;
        #1;
        expect_bit("midreset_wr_inc", tx.wr_inc, 1'b0);
        expect_bit("midreset_busy", tx.busy, 1'b0);
        expect_bit("midreset_overrun", tx.overrun, 1'b0);
        vectors++;
        if (tx.wr_data !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL midreset_wr_data: got %h, expected 00", tx.wr_data);
        end
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            expect_bit("post_reset_wr_inc", tx.wr_inc, 1'b0);
            next_cycle();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_read();
        test_alu_result();
        test_backpressure();
        test_collision();
        test_overrun_in_lo();
        test_stall_drop();
        test_back_to_back();
        test_reset_mid_frame();
        repeat (2) next_cycle();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL pending_bytes: got %0d unwritten, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
